// File: rtl/pattern1_checker_if.sv
// Bus bundle for pattern1_checker: received word, counter clear and checker status.
// The slave modport is the checker side; the master modport is the driving/observing side.
interface pattern1_checker_if;
  logic [15:0] i_DATA;
  logic        i_CLR;
  logic        o_LOCKED;
  logic        o_ERR;
  logic [15:0] o_ERR_CNT;
  logic        o_BITSLIP;

  modport master (
    output i_DATA,
    output i_CLR,
    input  o_LOCKED,
    input  o_ERR,
    input  o_ERR_CNT,
    input  o_BITSLIP
  );

  modport slave (
    input  i_DATA,
    input  i_CLR,
    output o_LOCKED,
    output o_ERR,
    output o_ERR_CNT,
    output o_BITSLIP
  );
endinterface

// File: rtl/pattern1_checker.sv
// pattern1_checker: locks onto the repeating word sequence 591D,0F5F,A324,B8A1 and counts
// mismatched words while locked. All outputs are registered (one cycle latency).
// Optional feature macro PATTERN1_CHECKER_BITSLIP_EN: on a HUNT miss, pulse o_BITSLIP and wait
// SLIP_WAIT cycles in SLIP before hunting again. Without it, o_BITSLIP is tied low.
module pattern1_checker #(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned SLIP_WAIT  = 16
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  pattern1_checker_if.slave    bus_io
);

  if (LOCK_CNT < 2 || LOCK_CNT > 255) begin : g_bad_lock_cnt
    $error("LOCK_CNT must be in 2..255");
  end
  if (UNLOCK_CNT < 1 || UNLOCK_CNT > 255) begin : g_bad_unlock_cnt
    $error("UNLOCK_CNT must be in 1..255");
  end
  if (SLIP_WAIT < 1 || SLIP_WAIT > 255) begin : g_bad_slip_wait
    $error("SLIP_WAIT must be in 1..255");
  end

  typedef enum logic [1:0] {StHunt, StVerify, StLocked, StSlip} state_e;

  localparam logic [7:0] LockTarget   = 8'(LOCK_CNT);
  localparam logic [7:0] UnlockTarget = 8'(UNLOCK_CNT);

  function automatic logic [15:0] exp_word(input logic [1:0] idx);
    case (idx)
      2'd0:    exp_word = 16'h591D;
      2'd1:    exp_word = 16'h0F5F;
      2'd2:    exp_word = 16'hA324;
      default: exp_word = 16'hB8A1;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  match_cnt_q, match_cnt_d;
  logic [7:0]  run_q, run_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_inc;
  logic        hunt_hit;
  logic [1:0]  hunt_idx;
  logic        is_match;

`ifdef PATTERN1_CHECKER_BITSLIP_EN
  localparam logic [7:0] SlipLast = 8'(SLIP_WAIT - 1);
  logic [7:0] slip_cnt_q, slip_cnt_d;
  logic       bitslip_q, bitslip_d;
`endif

  // Next-state logic: sequence tracking, lock/unlock decisions and error counting.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    match_cnt_d = match_cnt_q;
    run_d       = run_q;
    err_d       = 1'b0;
    err_inc     = 1'b0;
`ifdef PATTERN1_CHECKER_BITSLIP_EN
    slip_cnt_d  = slip_cnt_q;
    bitslip_d   = 1'b0;
`endif

    // Any of the four words can start acquisition; remember which one matched.
    hunt_hit = 1'b0;
    hunt_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (bus_io.i_DATA == exp_word(2'(k))) begin
        hunt_hit = 1'b1;
        hunt_idx = 2'(k);
      end
    end
    is_match = (bus_io.i_DATA == exp_word(idx_q));

    case (state_q)
      StHunt: begin
        if (hunt_hit) begin
          idx_d       = hunt_idx + 2'd1;
          match_cnt_d = 8'd1;
          state_d     = StVerify;
        end else begin
`ifdef PATTERN1_CHECKER_BITSLIP_EN
          state_d    = StSlip;
          bitslip_d  = 1'b1;
          slip_cnt_d = 8'd0;
`endif
        end
      end
      StVerify: begin
        if (is_match) begin
          idx_d       = idx_q + 2'd1;
          match_cnt_d = match_cnt_q + 8'd1;
          run_d       = 8'd0;
          if (match_cnt_d == LockTarget) state_d = StLocked;
        end else begin
          state_d     = StHunt;
          idx_d       = 2'd0;
          match_cnt_d = 8'd0;
        end
      end
      StLocked: begin
        // Index advances regardless so a single corrupted word does not realign.
        idx_d = idx_q + 2'd1;
        if (is_match) begin
          run_d = 8'd0;
        end else begin
          err_d   = 1'b1;
          err_inc = 1'b1;
          run_d   = run_q + 8'd1;
          if (run_d == UnlockTarget) begin
            state_d     = StHunt;
            run_d       = 8'd0;
            match_cnt_d = 8'd0;
            idx_d       = 2'd0;
          end
        end
      end
`ifdef PATTERN1_CHECKER_BITSLIP_EN
      StSlip: begin
        if (slip_cnt_q == SlipLast) begin
          state_d    = StHunt;
          slip_cnt_d = 8'd0;
        end else begin
          slip_cnt_d = slip_cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = StHunt;
    endcase

    // Clear beats a simultaneous increment; the count sticks at all-ones.
    err_cnt_d = err_cnt_q;
    if (bus_io.i_CLR) begin
      err_cnt_d = 16'h0000;
    end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end

    locked_d = (state_d == StLocked);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= StHunt;
      idx_q       <= 2'd0;
      match_cnt_q <= 8'd0;
      run_q       <= 8'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      match_cnt_q <= match_cnt_d;
      run_q       <= run_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

`ifdef PATTERN1_CHECKER_BITSLIP_EN
  // Slip wait counter and bitslip pulse register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      slip_cnt_q <= 8'd0;
      bitslip_q  <= 1'b0;
    end else begin
      slip_cnt_q <= slip_cnt_d;
      bitslip_q  <= bitslip_d;
    end
  end

  assign bus_io.o_BITSLIP = bitslip_q;
`else
  assign bus_io.o_BITSLIP = 1'b0;
`endif

  assign bus_io.o_LOCKED  = locked_q;
  assign bus_io.o_ERR     = err_q;
  assign bus_io.o_ERR_CNT = err_cnt_q;

endmodule

// File: doc/pattern1_checker.md
PATTERN1_CHECKER -- requirements
Module: pattern1_checker

Interface
REQ-001 Parameter LOCK_CNT, default 8: consecutive correct words required to declare lock (range 2..255).
REQ-002 Parameter UNLOCK_CNT, default 4: consecutive wrong words while locked required to drop lock (range 1..255).
REQ-003 Parameter SLIP_WAIT, default 16: idle cycles after a bitslip pulse before hunting resumes (range 1..255).
REQ-004 Port i_CLK  input  1: single clock; all logic on its rising edge.
REQ-005 Port i_RST  input  1: reset, synchronous, active-high.
REQ-006 Port i_DATA  input  16: received word, one word per cycle, no valid qualifier.
REQ-007 Port i_CLR  input  1: synchronous clear of o_ERR_CNT.
REQ-008 Port o_LOCKED  output  1: high while in LOCKED state.
REQ-009 Port o_ERR  output  1: one-cycle pulse per mismatched word while locked.
REQ-010 Port o_ERR_CNT  output  16: saturating count of mismatched words while locked.
REQ-011 Port o_BITSLIP  output  1: one-cycle bitslip request to the deserializer.

Function
REQ-012 Expected sequence SHALL be the repeating cycle 591D -> 0F5F -> A324 -> B8A1 -> 591D (hex), indices 0..3, index wraps 3 -> 0.
REQ-013 All outputs SHALL be registered; response to i_DATA sampled at edge N appears after edge N (latency 1 cycle).
REQ-014 States SHALL be HUNT, VERIFY, LOCKED, SLIP (SLIP reachable only with the feature macro defined).
REQ-015 HUNT: i_DATA equal to any of the 4 words -> expected index = that index + 1 (mod 4), match count = 1, go VERIFY.
REQ-016 HUNT: i_DATA matching none of the 4 words -> stay HUNT (macro undefined) or go SLIP (macro defined, per REQ-026).
REQ-017 VERIFY: match -> match count + 1, index + 1; when count reaches LOCK_CNT go LOCKED on the same edge.
REQ-018 VERIFY: mismatch -> go HUNT, match count cleared, o_ERR not pulsed, o_ERR_CNT unchanged.
REQ-019 LOCKED: match -> index + 1, consecutive-error run cleared to 0.
REQ-020 LOCKED: mismatch -> o_ERR = 1 next cycle, o_ERR_CNT + 1, run + 1, index still advances (single-word corruption does not realign).
REQ-021 LOCKED: run reaching UNLOCK_CNT -> go HUNT, o_LOCKED low next cycle; the mismatch causing the unlock is still counted.
REQ-022 o_ERR_CNT SHALL saturate at FFFF and hold until i_CLR or reset.
REQ-023 i_CLR with a simultaneous increment SHALL leave o_ERR_CNT = 0 (clear wins).
REQ-024 o_LOCKED SHALL be asserted only in LOCKED state; o_ERR SHALL never pulse outside LOCKED.

Reset
REQ-025 i_RST high at an edge SHALL force state HUNT, index 0, match count 0, run 0, SLIP counter 0, o_LOCKED 0, o_ERR 0, o_ERR_CNT 0, o_BITSLIP 0, overriding all other inputs including mid-lock and mid-SLIP.

Configuration
REQ-026 Macro PATTERN1_CHECKER_BITSLIP_EN defined: HUNT mismatch -> o_BITSLIP = 1 for exactly one cycle, enter SLIP, stay SLIP_WAIT cycles ignoring i_DATA, then return to HUNT.
REQ-027 Macro PATTERN1_CHECKER_BITSLIP_EN undefined: SLIP state and counter not built, o_BITSLIP tied 0, HUNT mismatch stays in HUNT.

Verification
REQ-028 Reset, then 591D,0F5F,A324,B8A1 repeated -> o_LOCKED rises one cycle after the 8th word; o_ERR_CNT stays 0.
REQ-029 Locked, one word replaced by 0000 -> single o_ERR pulse, o_ERR_CNT = 1, o_LOCKED stays 1, following correct words produce no errors.
REQ-030 Locked, 4 consecutive 0000 words -> o_ERR_CNT = 4, o_LOCKED falls one cycle after the 4th; resumed clean pattern relocks after 8 words.
REQ-031 o_ERR_CNT forced to FFFF by sustained locked errors -> holds FFFF; i_CLR coincident with an error -> 0000.
REQ-032 Macro defined, constant input 1234 -> o_BITSLIP pulses once every 17 cycles (1 HUNT + 16 SLIP); macro undefined -> o_BITSLIP stays 0.
REQ-033 i_RST asserted while locked at count 5 -> next cycle o_LOCKED 0, o_ERR_CNT 0, state HUNT.
